huc_sram_ctrl: RTL and testbench

//  Memory-side responder for the MemCtrl request bundle emitted by HuCard mappers (rom/ram channels).

---
 rtl/huc_pkg.sv | 26 ++
 rtl/huc_req_det.sv | 61 ++++++
 rtl/huc_sram_ctrl.sv | 124 ++++++++++++
 tb/tb_huc_sram_ctrl.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/huc_pkg.sv
// huc_pkg: types shared by the HuCard memory-side blocks.
//   MemCtrl - request bundle driven by the mappers (rom/ram channels)
//   SramSt  - state of the timed SRAM/PSRAM access sequencer
//   max3    - elaboration helper used to size wait counters
package huc_pkg;

    localparam int MEM_AW = 24;

    typedef struct packed {
        logic [MEM_AW-1:0] addr;
        logic [7:0]        dati;
        logic              ce;     // chip select
        logic              ce2;    // cycle strobe, a rising edge starts a request
        logic              oe;
        logic              we;
    } MemCtrl;

    typedef enum logic [1:0] {IDLE, RD, WR, REC} SramSt;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/huc_req_det.sv
// huc_req_det: request detector with a one-deep pending slot.
//   clk, rst  - clock, asynchronous active-high reset
//   mem       - mapper request bundle (synchronous to clk)
//   req_take  - sequencer accepts the presented request this cycle
//   req_vld   - a request is presented (pending slot first, else a fresh start)
//   req_wr    - presented request is a write
//   req_addr  - presented request address
//   req_dat   - presented request write data
module huc_req_det
    import huc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  MemCtrl            mem,
    input  logic              req_take,
    output logic              req_vld,
    output logic              req_wr,
    output logic [MEM_AW-1:0] req_addr,
    output logic [7:0]        req_dat
);

    logic              ce2_d;
    logic              start;
    logic              pend_vld;
    logic              pend_wr;
    logic [MEM_AW-1:0] pend_addr;
    logic [7:0]        pend_dat;

    // ce2_d tracks ce2 regardless of ce, so a ce2 level that rose while
    // deselected can never start an access later.
    assign start = mem.ce2 & ~ce2_d & mem.ce & (mem.we | mem.oe);

    assign req_vld  = pend_vld | start;
    assign req_wr   = pend_vld ? pend_wr   : mem.we;
    assign req_addr = pend_vld ? pend_addr : mem.addr;
    assign req_dat  = pend_vld ? pend_dat  : mem.dati;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ce2_d     <= 1'b0;
            pend_vld  <= 1'b0;
            pend_wr   <= 1'b0;
            pend_addr <= '0;
            pend_dat  <= '0;
        end else begin
            ce2_d <= mem.ce2;
            // A start is parked when it cannot go straight in: either the
            // sequencer is not taking, or it is taking the older pending one.
            // Parking over a full slot overwrites it (last request wins).
            if (start && (pend_vld || !req_take)) begin
                pend_vld  <= 1'b1;
                pend_wr   <= mem.we;
                pend_addr <= mem.addr;
                pend_dat  <= mem.dati;
            end else if (req_take) begin
                pend_vld  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/huc_sram_ctrl.sv
// huc_sram_ctrl: turns each mapper request into one timed async SRAM/PSRAM
// cycle and returns read data.
//   clk, rst    - clock, asynchronous active-high reset
//   mem         - mapper request bundle
//   dato        - last read data, held until the next read completes
//   busy        - access or recovery in progress
//   sram_addr   - registered pad address, stable for the whole access
//   sram_dq_i   - data from the pads
//   sram_dq_o   - data to the pads
//   sram_dq_oe  - pad driver enable
//   sram_ce_n   - chip enable, active-low
//   sram_oe_n   - output enable, active-low
//   sram_we_n   - write enable, active-low
module huc_sram_ctrl
    import huc_pkg::*;
#(
    parameter int AW      = 22,
    parameter int RD_WAIT = 4,
    parameter int WR_WAIT = 4,
    parameter int REC_CYC = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  MemCtrl        mem,
    output logic [7:0]    dato,
    output logic          busy,
    output logic [AW-1:0] sram_addr,
    input  logic [7:0]    sram_dq_i,
    output logic [7:0]    sram_dq_o,
    output logic          sram_dq_oe,
    output logic          sram_ce_n,
    output logic          sram_oe_n,
    output logic          sram_we_n
);

    localparam int CW = $clog2(max3(RD_WAIT, WR_WAIT, REC_CYC) + 1);
    localparam logic [CW-1:0] RD_LD  = CW'(RD_WAIT - 1);
    localparam logic [CW-1:0] WR_LD  = CW'(WR_WAIT - 1);
    localparam logic [CW-1:0] REC_LD = CW'(REC_CYC - 1);

    SramSt              state;
    logic [CW-1:0]      cnt;
    logic               take;
    logic               req_vld;
    logic               req_wr;
    logic [MEM_AW-1:0]  req_addr;
    logic [7:0]         req_dat;

    huc_req_det u_req_det (
        .clk      (clk),
        .rst      (rst),
        .mem      (mem),
        .req_take (take),
        .req_vld  (req_vld),
        .req_wr   (req_wr),
        .req_addr (req_addr),
        .req_dat  (req_dat)
    );

    // New access may begin from IDLE or on the last recovery cycle, which
    // gives back-to-back accesses without an idle bubble.
    assign take = req_vld && ((state == IDLE) || ((state == REC) && (cnt == '0)));
    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            dato       <= 8'hFF;
            sram_addr  <= '0;
            sram_dq_o  <= '0;
            sram_dq_oe <= 1'b0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
        end else if (take) begin
            state      <= req_wr ? WR : RD;
            cnt        <= req_wr ? WR_LD : RD_LD;
            sram_addr  <= AW'(req_addr);
            sram_ce_n  <= 1'b0;
            sram_oe_n  <= req_wr;
            sram_we_n  <= ~req_wr;
            sram_dq_oe <= req_wr;
            if (req_wr)
                sram_dq_o <= req_dat;
        end else begin
            case (state)
                IDLE: ;
                RD: begin
                    if (cnt == '0) begin
                        dato      <= sram_dq_i;
                        state     <= REC;
                        cnt       <= REC_LD;
                        sram_ce_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WR: begin
                    // dq stays driven into recovery for data hold time
                    if (cnt == '0) begin
                        state     <= REC;
                        cnt       <= REC_LD;
                        sram_ce_n <= 1'b1;
                        sram_we_n <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                REC: begin
                    if (cnt == '0) begin
                        state      <= IDLE;
                        sram_dq_oe <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_huc_sram_ctrl.sv
// tb_huc_sram_ctrl: self-checking bench for huc_sram_ctrl. A pin monitor
// records every completed access; each scenario pushes the accesses it
// expects and compares them against the recorded ones.
module tb_huc_sram_ctrl;
    import huc_pkg::*;

    localparam int AW = 22;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [7:0]    dat;
        int            len;
    } acc_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // default-timing instance
    MemCtrl        mem;
    logic [7:0]    dato, sram_dq_i, sram_dq_o;
    logic          busy, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
    logic [AW-1:0] sram_addr;

    // single-cycle-timing instance
    MemCtrl        fmem;
    logic [7:0]    f_dato, f_dq_i, f_dq_o;
    logic          f_busy, f_dq_oe, f_ce_n, f_oe_n, f_we_n;
    logic [AW-1:0] f_addr;

    huc_sram_ctrl #(.AW(AW), .RD_WAIT(4), .WR_WAIT(4), .REC_CYC(1)) dut (
        .clk(clk), .rst(rst), .mem(mem), .dato(dato), .busy(busy),
        .sram_addr(sram_addr), .sram_dq_i(sram_dq_i), .sram_dq_o(sram_dq_o),
        .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n)
    );

    huc_sram_ctrl #(.AW(AW), .RD_WAIT(1), .WR_WAIT(1), .REC_CYC(1)) dut_f (
        .clk(clk), .rst(rst), .mem(fmem), .dato(f_dato), .busy(f_busy),
        .sram_addr(f_addr), .sram_dq_i(f_dq_i), .sram_dq_o(f_dq_o),
        .sram_dq_oe(f_dq_oe), .sram_ce_n(f_ce_n), .sram_oe_n(f_oe_n),
        .sram_we_n(f_we_n)
    );

    // SRAM model (low address byte only), with a preload port
    logic [7:0] mem_m [0:255];
    logic       pl_en = 1'b0;
    logic [7:0] pl_addr, pl_dat;
    always @(posedge clk) begin
        if (pl_en)
            mem_m[pl_addr] <= pl_dat;
        else if (!sram_ce_n && !sram_we_n && sram_dq_oe)
            mem_m[sram_addr[7:0]] <= sram_dq_o;
    end
    assign sram_dq_i = mem_m[sram_addr[7:0]];
    assign f_dq_i    = f_addr[7:0] ^ 8'h5A;

    int   n_chk = 0;
    int   n_bad = 0;
    acc_t exp_q[$];
    acc_t obs_q[$];
    logic overlap = 1'b0;

    // pin monitor: one record per ce_n low window
    initial begin
        acc_t cur;
        logic prev;
        prev = 1'b1;
        cur  = '{1'b0, '0, 8'h00, 0};
        forever begin
            @(negedge clk);
            if (prev && !sram_ce_n) begin
                cur.wr   = !sram_we_n;
                cur.addr = sram_addr;
                cur.dat  = !sram_we_n ? sram_dq_o : sram_dq_i;
                cur.len  = 0;
            end
            if (!sram_ce_n && (cur.wr ? !sram_we_n : !sram_oe_n))
                cur.len++;
            if (!prev && sram_ce_n)
                obs_q.push_back(cur);
            if (!sram_oe_n && !sram_we_n)
                overlap = 1'b1;
            prev = sram_ce_n;
        end
    end

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_dat = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        mem = '0;
        fmem = '0;
        repeat (2) @(negedge clk);
        n_chk++;
        if ({dato, busy, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, sram_dq_o, sram_addr} !==
            {8'hFF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, {AW{1'b0}}}) begin
            n_bad++;
            $display("FAIL reset_vals: dato=%h busy=%b ce/oe/we=%b%b%b dq_oe=%b dq_o=%h addr=%h",
                     dato, busy, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, sram_dq_o, sram_addr);
        end
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if (busy !== 1'b0 || dato !== 8'hFF) begin
            n_bad++;
            $display("FAIL reset_release: busy=%b dato=%h want 0 ff", busy, dato);
        end
    endtask

    task automatic test_read;
        bit   ok;
        acc_t e, o;
        preload(8'h34, 8'hA5);
        @(negedge clk);
        mem.addr = 24'h001234; mem.ce = 1'b1; mem.oe = 1'b1; mem.we = 1'b0; mem.ce2 = 1'b1;
        exp_q.push_back('{1'b0, 22'h001234, 8'hA5, 4});
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            n_chk++;
            case (c)
                1: if (sram_addr !== 22'h001234 || sram_ce_n !== 1'b0 || sram_oe_n !== 1'b0 || busy !== 1'b1) begin
                       n_bad++;
                       $display("FAIL rd_start: addr=%h ce_n=%b oe_n=%b busy=%b", sram_addr, sram_ce_n, sram_oe_n, busy);
                   end
                4: if (dato !== 8'hFF) begin
                       n_bad++;
                       $display("FAIL rd_early: dato=%h want ff", dato);
                   end
                5: if (dato !== 8'hA5 || sram_ce_n !== 1'b1 || busy !== 1'b1) begin
                       n_bad++;
                       $display("FAIL rd_latency: dato=%h ce_n=%b busy=%b want a5 1 1", dato, sram_ce_n, busy);
                   end
                6: if (busy !== 1'b0) begin
                       n_bad++;
                       $display("FAIL rd_done: busy=%b want 0", busy);
                   end
                default: if (sram_oe_n !== 1'b0) begin
                       n_bad++;
                       $display("FAIL rd_oe_hold: oe_n=%b want 0 at cycle %0d", sram_oe_n, c);
                   end
            endcase
            if (c == 1) mem.ce2 = 1'b0;
        end
        wait_idle(ok);
        n_chk++;
        if (obs_q.size() !== exp_q.size()) begin
            n_bad++;
            $display("FAIL rd_count: got %0d accesses want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_chk++;
            if (o.wr !== e.wr || o.addr !== e.addr || o.dat !== e.dat || o.len !== e.len) begin
                n_bad++;
                $display("FAIL rd_access: got wr=%b a=%h d=%h len=%0d want wr=%b a=%h d=%h len=%0d",
                         o.wr, o.addr, o.dat, o.len, e.wr, e.addr, e.dat, e.len);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_write;
        bit   ok;
        acc_t e, o;
        @(negedge clk);
        mem.addr = 24'h007FFF; mem.dati = 8'h3C; mem.we = 1'b1; mem.oe = 1'b0; mem.ce2 = 1'b1;
        exp_q.push_back('{1'b1, 22'h007FFF, 8'h3C, 4});
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) begin
                n_chk++;
                if (sram_we_n !== 1'b0 || sram_oe_n !== 1'b1 || sram_dq_oe !== 1'b1 || sram_dq_o !== 8'h3C) begin
                    n_bad++;
                    $display("FAIL wr_start: we_n=%b oe_n=%b dq_oe=%b dq_o=%h", sram_we_n, sram_oe_n, sram_dq_oe, sram_dq_o);
                end
                mem.ce2 = 1'b0;
            end
            if (c == 5) begin
                n_chk++;
                if (sram_ce_n !== 1'b1 || sram_we_n !== 1'b1 || sram_dq_oe !== 1'b1) begin
                    n_bad++;
                    $display("FAIL wr_hold: ce_n=%b we_n=%b dq_oe=%b want 1 1 1", sram_ce_n, sram_we_n, sram_dq_oe);
                end
            end
            if (c == 6) begin
                n_chk++;
                if (sram_dq_oe !== 1'b0 || busy !== 1'b0) begin
                    n_bad++;
                    $display("FAIL wr_release: dq_oe=%b busy=%b want 0 0", sram_dq_oe, busy);
                end
            end
        end
        wait_idle(ok);
        n_chk++;
        if (mem_m[8'hFF] !== 8'h3C || dato !== 8'hA5) begin
            n_bad++;
            $display("FAIL wr_effect: mem=%h dato=%h want 3c a5", mem_m[8'hFF], dato);
        end
        n_chk++;
        if (obs_q.size() !== exp_q.size()) begin
            n_bad++;
            $display("FAIL wr_count: got %0d accesses want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_chk++;
            if (o.wr !== e.wr || o.addr !== e.addr || o.dat !== e.dat || o.len !== e.len) begin
                n_bad++;
                $display("FAIL wr_access: got wr=%b a=%h d=%h len=%0d want wr=%b a=%h d=%h len=%0d",
                         o.wr, o.addr, o.dat, o.len, e.wr, e.addr, e.dat, e.len);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_pending;
        bit   ok;
        acc_t e, o;
        preload(8'h01, 8'h11);
        preload(8'h02, 8'h22);
        preload(8'h03, 8'h33);
        mem.we = 1'b0; mem.oe = 1'b1;
        // starts on every other cycle: addr 1 runs, 2 parks, 3 overwrites 2
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k > 1) begin
                n_chk++;
                if (busy !== 1'b1) begin
                    n_bad++;
                    $display("FAIL pend_busy: busy=%b want 1 at start %0d", busy, k);
                end
            end
            mem.addr = 24'(k); mem.ce2 = 1'b1;
            @(negedge clk);
            mem.ce2 = 1'b0;
        end
        exp_q.push_back('{1'b0, 22'h000001, 8'h11, 4});
        exp_q.push_back('{1'b0, 22'h000003, 8'h33, 4});
        wait_idle(ok);
        n_chk++;
        if (!ok || dato !== 8'h33) begin
            n_bad++;
            $display("FAIL pend_result: idle=%b dato=%h want 1 33", ok, dato);
        end
        n_chk++;
        if (obs_q.size() !== exp_q.size()) begin
            n_bad++;
            $display("FAIL pend_count: got %0d accesses want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_chk++;
            if (o.wr !== e.wr || o.addr !== e.addr || o.dat !== e.dat || o.len !== e.len) begin
                n_bad++;
                $display("FAIL pend_access: got wr=%b a=%h d=%h len=%0d want wr=%b a=%h d=%h len=%0d",
                         o.wr, o.addr, o.dat, o.len, e.wr, e.addr, e.dat, e.len);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_ce2_level;
        bit   ok;
        int   active;
        acc_t e, o;
        preload(8'h40, 8'h5A);
        @(negedge clk);
        mem.addr = 24'h000040; mem.oe = 1'b1; mem.we = 1'b0; mem.ce = 1'b1; mem.ce2 = 1'b1;
        exp_q.push_back('{1'b0, 22'h000040, 8'h5A, 4});
        repeat (20) @(negedge clk);
        mem.ce2 = 1'b0;
        wait_idle(ok);
        // deselected strobe must not touch the pins
        mem.ce = 1'b0;
        @(negedge clk);
        mem.ce2 = 1'b1;
        active = 0;
        repeat (10) begin
            @(negedge clk);
            if (sram_ce_n !== 1'b1 || busy !== 1'b0) active++;
        end
        mem.ce2 = 1'b0;
        @(negedge clk);
        mem.ce = 1'b1;
        n_chk++;
        if (active !== 0) begin
            n_bad++;
            $display("FAIL ce0_ignored: %0d active cycles want 0", active);
        end
        n_chk++;
        if (obs_q.size() !== exp_q.size()) begin
            n_bad++;
            $display("FAIL level_count: got %0d accesses want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_chk++;
            if (o.wr !== e.wr || o.addr !== e.addr || o.dat !== e.dat || o.len !== e.len) begin
                n_bad++;
                $display("FAIL level_access: got wr=%b a=%h d=%h len=%0d want wr=%b a=%h d=%h len=%0d",
                         o.wr, o.addr, o.dat, o.len, e.wr, e.addr, e.dat, e.len);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_mid;
        bit   ok;
        acc_t e, o;
        @(negedge clk);
        mem.addr = 24'h000055; mem.dati = 8'h77; mem.oe = 1'b1; mem.we = 1'b1; mem.ce2 = 1'b1;
        @(negedge clk);
        n_chk++;
        if (sram_ce_n !== 1'b0 || sram_we_n !== 1'b0 || sram_oe_n !== 1'b1) begin
            n_bad++;
            $display("FAIL we_priority: ce_n=%b we_n=%b oe_n=%b want 0 0 1", sram_ce_n, sram_we_n, sram_oe_n);
        end
        mem.ce2 = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if ({sram_ce_n, sram_we_n, sram_oe_n, sram_dq_oe, busy, dato} !== {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF}) begin
            n_bad++;
            $display("FAIL async_rst: ce/we/oe=%b%b%b dq_oe=%b busy=%b dato=%h",
                     sram_ce_n, sram_we_n, sram_oe_n, sram_dq_oe, busy, dato);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete(); obs_q.delete();
        @(negedge clk);
        mem.addr = 24'h007FFF; mem.oe = 1'b1; mem.we = 1'b0; mem.ce2 = 1'b1;
        exp_q.push_back('{1'b0, 22'h007FFF, 8'h3C, 4});
        @(negedge clk);
        mem.ce2 = 1'b0;
        wait_idle(ok);
        n_chk++;
        if (!ok || dato !== 8'h3C) begin
            n_bad++;
            $display("FAIL post_rst_read: idle=%b dato=%h want 1 3c", ok, dato);
        end
        n_chk++;
        if (obs_q.size() !== exp_q.size()) begin
            n_bad++;
            $display("FAIL post_rst_count: got %0d accesses want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_chk++;
            if (o.wr !== e.wr || o.addr !== e.addr || o.dat !== e.dat || o.len !== e.len) begin
                n_bad++;
                $display("FAIL post_rst_access: got wr=%b a=%h d=%h len=%0d want wr=%b a=%h d=%h len=%0d",
                         o.wr, o.addr, o.dat, o.len, e.wr, e.addr, e.dat, e.len);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_back_to_back;
        logic [3:0] tbl [5];
        logic [3:0] got;
        // expected {ce_n, oe_n, we_n, dq_oe} per cycle: RD, REC, WR, REC, IDLE
        tbl = '{4'b0010, 4'b1110, 4'b0101, 4'b1111, 4'b1110};
        @(negedge clk);
        fmem.addr = 24'h000010; fmem.ce = 1'b1; fmem.oe = 1'b1; fmem.we = 1'b0; fmem.ce2 = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            got = {f_ce_n, f_oe_n, f_we_n, f_dq_oe};
            n_chk++;
            if (got !== tbl[c] || (!f_oe_n && !f_we_n)) begin
                n_bad++;
                $display("FAIL b2b_pins: cycle %0d got %b want %b", c, got, tbl[c]);
            end
            if (c == 0) begin
                fmem.ce2 = 1'b0; fmem.we = 1'b1; fmem.oe = 1'b0; fmem.addr = 24'h000020; fmem.dati = 8'h99;
            end
            if (c == 1) begin
                n_chk++;
                if (f_dato !== 8'h4A || f_busy !== 1'b1) begin
                    n_bad++;
                    $display("FAIL b2b_read: dato=%h busy=%b want 4a 1", f_dato, f_busy);
                end
                fmem.ce2 = 1'b1;
            end
            if (c == 2) begin
                n_chk++;
                if (f_dq_o !== 8'h99 || f_addr !== 22'h000020) begin
                    n_bad++;
                    $display("FAIL b2b_write: dq_o=%h addr=%h want 99 20", f_dq_o, f_addr);
                end
                fmem.ce2 = 1'b0;
            end
        end
        n_chk++;
        if (f_dato !== 8'h4A || f_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_end: dato=%h busy=%b want 4a 0", f_dato, f_busy);
        end
        n_chk++;
        if (overlap !== 1'b0) begin
            n_bad++;
            $display("FAIL oe_we_overlap: flag=%b want 0", overlap);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        mem = '0;
        fmem = '0;
        test_reset();
        test_read();
        test_write();
        test_pending();
        test_ce2_level();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
